dac_spi_tx: RTL and testbench

//  Downstream stage of the QAM modulator. Takes the 16-bit mixed QAM sample and

---
 rtl/dac_spi_tx_pkg.sv | 21 ++
 rtl/dac_spi_tx_bit_timer.sv | 38 +++
 rtl/dac_spi_tx.sv | 159 +++++++++++++++
 tb/tb_dac_spi_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_tx_pkg.sv
// Shared widths, DAC command byte, frame layout and FSM encoding for the DAC SPI transmitter.
package dac_spi_tx_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned DAC_FRAME_W = 24;
  localparam int unsigned BIT_CNT_W   = 5;

  localparam logic [7:0] DAC_CMD_WR_UPD = 8'h30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_e;

  typedef struct packed {
    logic [7:0]          cmd;
    logic [SAMPLE_W-1:0] sample;
  } dac_frame_t;

endpackage

// File: rtl/dac_spi_tx_bit_timer.sv
// SCLK divider: CLK_DIV clk cycles per half-period, mode 0 (idle low) while run is low.
module dac_spi_tx_bit_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0] div_cnt;
  logic             phase_end_c;

  assign phase_end_c = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_tick_c = phase_end_c && !sclk;
  assign fall_tick_c = phase_end_c && sclk;

  // Half-period counter; sclk toggles at the end of every phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (phase_end_c) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 16-bit QAM samples into 24-bit {CMD, sample} SPI frames for an external DAC,
// with a one-deep input buffer and a sticky overrun flag.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [7:0]  CMD        = DAC_CMD_WR_UPD,
  parameter int unsigned CS_GAP     = 2,
  parameter bit          OFFSET_BIN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                overrun,
  output logic                busy,
  output logic                frame_done,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_mosi
);

  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [SAMPLE_W-1:0] MSB_FLIP = {OFFSET_BIN, {(SAMPLE_W - 1){1'b0}}};

  dac_state_e               state_q, state_d;
  logic [SAMPLE_W-1:0]      buf_q, buf_d;
  logic                     buf_valid_q, buf_valid_d;
  logic [DAC_FRAME_W-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic                     cs_n_q, cs_n_d;
  logic                     mosi_q, mosi_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overrun_q, overrun_d;
  logic                     busy_q, busy_d;
  logic                     ready_q, ready_d;
  dac_frame_t               load_frame;
  logic                     rise_tick_c;
  logic                     fall_tick_c;

  assign load_frame = '{cmd: CMD, sample: buf_q};

  dac_spi_tx_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (state_q == ST_SHIFT),
    .sclk        (dac_sclk),
    .rise_tick_c (rise_tick_c),
    .fall_tick_c (fall_tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (buf_valid_q) begin
          state_d     = ST_SHIFT;
          shift_d     = load_frame;
          buf_valid_d = 1'b0;
          cs_n_d      = 1'b0;
          mosi_d      = load_frame.cmd[7];
          bit_cnt_d   = BIT_CNT_W'(DAC_FRAME_W - 1);
        end
      end
      ST_SHIFT: begin
        // mosi only moves on sclk falling edges so the DAC samples a settled bit.
        if (fall_tick_c) begin
          if (bit_cnt_q == '0) begin
            state_d      = ST_GAP;
            cs_n_d       = 1'b1;
            mosi_d       = 1'b0;
            frame_done_d = 1'b1;
            gap_cnt_d    = '0;
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            mosi_d    = shift_q[DAC_FRAME_W-2];
            shift_d   = shift_q << 1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe while the buffer is full (including the drain edge) is lost.
    if (sample_valid) begin
      if (ready_q) begin
        buf_d       = sample_in ^ MSB_FLIP;
        buf_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d  = (state_d != ST_IDLE);
    ready_d = !buf_valid_d;
  end

  // sclk must never pulse outside an asserted chip select.
  assert property (@(posedge clk) disable iff (rst) rise_tick_c |-> !dac_cs_n);

  assign sample_ready = ready_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_mosi     = mosi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: frames captured off the SPI pins of an offset-binary
// instance and a pass-through instance are compared against queued expectations.
module tb_dac_spi_tx;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_GAP  = 2;
  localparam logic [7:0]  CMD     = 8'h30;
  localparam int          FD_LAT  = 1 + 48 * CLK_DIV;

  logic        clk;
  logic        rst;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready, overrun, busy, frame_done, dac_cs_n, dac_sclk, dac_mosi;
  logic        sample_ready_b, overrun_b, busy_b, frame_done_b, dac_cs_n_b, dac_sclk_b, dac_mosi_b;

  dac_spi_tx #(.CLK_DIV(CLK_DIV), .CMD(CMD), .CS_GAP(CS_GAP), .OFFSET_BIN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .busy(busy), .frame_done(frame_done),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_mosi(dac_mosi)
  );

  dac_spi_tx #(.CLK_DIV(CLK_DIV), .CMD(CMD), .CS_GAP(CS_GAP), .OFFSET_BIN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready_b), .overrun(overrun_b), .busy(busy_b), .frame_done(frame_done_b),
    .dac_cs_n(dac_cs_n_b), .dac_sclk(dac_sclk_b), .dac_mosi(dac_mosi_b)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc;

  logic [23:0] exp0[$];
  logic [23:0] expb[$];

  // monitor state, offset-binary instance
  logic        sclk_q0, cs_q0;
  logic [23:0] frm0;
  int          nb0, frames0, rise_cyc0, gap0, fd_cyc0;
  // monitor state, pass-through instance
  logic        sclk_qb, cs_qb;
  logic [23:0] frmb;
  int          nbb, framesb;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic drive(input logic [15:0] s, input logic exp_ready, input logic push);
    check("ready_at_strobe", sample_ready, exp_ready);
    sample_in    = s;
    sample_valid = 1'b1;
    if (push) begin
      exp0.push_back({CMD, s ^ 16'h8000});
      expb.push_back({CMD, s});
    end
    step();
    acc_cyc      = cyc;
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int b = 0;
    while (frames0 < target && b < 3000) begin
      step();
      b++;
    end
    step();
    check("frames_seen", frames0, target);
    check("frames_seen_b", framesb, target);
  endtask

  // Capture bits on sclk rises; a cs_n rise outside reset closes a frame.
  always @(negedge clk) begin
    logic [23:0] e;
    if (dac_sclk === 1'b1 && sclk_q0 === 1'b0) begin
      frm0 = {frm0[22:0], dac_mosi};
      nb0++;
    end
    if (dac_cs_n === 1'b0 && cs_q0 === 1'b1) begin
      frm0 = '0;
      nb0  = 0;
      gap0 = cyc - rise_cyc0;
    end
    if (dac_cs_n === 1'b1 && cs_q0 === 1'b0) begin
      rise_cyc0 = cyc;
      if (!rst) begin
        e = (exp0.size() != 0) ? exp0.pop_front() : 24'hxxxxxx;
        check("bit_count", nb0, 24);
        check("frame", frm0, e);
        frames0++;
      end
    end
    if (frame_done === 1'b1) fd_cyc0 = cyc;
    sclk_q0 = dac_sclk;
    cs_q0   = dac_cs_n;
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (dac_sclk_b === 1'b1 && sclk_qb === 1'b0) begin
      frmb = {frmb[22:0], dac_mosi_b};
      nbb++;
    end
    if (dac_cs_n_b === 1'b0 && cs_qb === 1'b1) begin
      frmb = '0;
      nbb  = 0;
    end
    if (dac_cs_n_b === 1'b1 && cs_qb === 1'b0 && !rst) begin
      e = (expb.size() != 0) ? expb.pop_front() : 24'hxxxxxx;
      check("bit_count_b", nbb, 24);
      check("frame_b", frmb, e);
      framesb++;
    end
    sclk_qb = dac_sclk_b;
    cs_qb   = dac_cs_n_b;
  end

  initial begin
    int start;
    int b;
    rst = 1'b1; sample_in = '0; sample_valid = 1'b0;
    frm0 = '0; nb0 = 0; frames0 = 0; rise_cyc0 = 0; gap0 = 0; fd_cyc0 = 0;
    frmb = '0; nbb = 0; framesb = 0;

    // reset values
    do_reset();
    check("rst_cs_n", dac_cs_n, 1'b1);
    check("rst_sclk", dac_sclk, 1'b0);
    check("rst_mosi", dac_mosi, 1'b0);
    check("rst_ready", sample_ready, 1'b1);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    // single frame, latency and busy
    start = frames0;
    drive(16'h8000, 1'b1, 1'b1);
    step(); step();
    check("busy_in_frame", busy, 1'b1);
    check("cs_low_in_frame", dac_cs_n, 1'b0);
    wait_frames(start + 1);
    check("frame_done_latency", 32'(fd_cyc0 - acc_cyc), 32'(FD_LAT));
    check("idle_after_frame", busy, 1'b0);

    // offset-binary boundary value
    start = frames0;
    drive(16'h7FFF, 1'b1, 1'b1);
    wait_frames(start + 1);

    // back-to-back strobes: third one overruns
    do_reset();
    start = frames0;
    drive(16'h1234, 1'b1, 1'b1);
    step();
    drive(16'h5678, 1'b1, 1'b1);
    step();
    drive(16'h9ABC, 1'b0, 1'b0);
    check("overrun_set", overrun, 1'b1);
    check("overrun_set_b", overrun_b, 1'b1);
    wait_frames(start + 2);
    check("cs_gap", 32'(gap0), 32'(CS_GAP + 1));
    repeat (120) step();
    check("no_extra_frame", frames0, start + 2);
    check("overrun_sticky", overrun, 1'b1);

    // paced input at the minimum period never overruns
    do_reset();
    start = frames0;
    for (int i = 0; i < 20; i++) begin
      drive(16'($urandom), 1'b1, 1'b1);
      repeat (FD_LAT + CS_GAP) step();
    end
    wait_frames(start + 20);
    check("paced_overrun", overrun, 1'b0);
    check("paced_overrun_b", overrun_b, 1'b0);

    // reset mid-frame abandons frame, buffer and overrun
    do_reset();
    start = frames0;
    drive(16'hAAAA, 1'b1, 1'b0);
    step();
    drive(16'h5555, 1'b1, 1'b0);
    step();
    drive(16'h0F0F, 1'b0, 1'b0);
    check("pre_rst_overrun", overrun, 1'b1);
    b = 0;
    while (nb0 < 10 && b < 200) begin
      step();
      b++;
    end
    check("reached_10_rises", nb0, 10);
    rst = 1'b1;
    step();
    check("midrst_cs_n", dac_cs_n, 1'b1);
    check("midrst_sclk", dac_sclk, 1'b0);
    check("midrst_ready", sample_ready, 1'b1);
    check("midrst_overrun", overrun, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    repeat (10) step();
    check("no_frame_from_flushed_buf", dac_cs_n, 1'b1);
    drive(16'h4321, 1'b1, 1'b1);
    wait_frames(start + 1);

    check("sb_empty", 32'(exp0.size()), 32'd0);
    check("sb_empty_b", 32'(expb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
